// File: rtl/key_event_scheduler.sv
// PS/2 scan-code decoder for ENTER/LEFT/RIGHT feeding a small event FIFO, with held-key and direction tracking.
// Define KEY_TYPEMATIC_FILTER_EN to suppress typematic repeat makes of keys that are already held.
module key_event_scheduler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  input  logic       evt_ready,
  output logic [2:0] held,
  output logic [1:0] move_dir,
  output logic       start_pulse,
  output logic       overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  typedef enum logic [1:0] {KEY_ENTER = 2'b00, KEY_LEFT = 2'b01, KEY_RIGHT = 2'b10} key_t;

  state_t state, next_state;

  logic             dec_fire;
  logic             dec_brk;
  key_t             dec_key;
  logic [2:0]       key_mask;
  logic             evt_fire;
  logic             push;
  logic             pop;
  logic             full;

  logic [2:0]       held_q, held_next;
  logic [1:0]       move_q, move_next;
  logic             start_q;
  logic             overflow_q;

  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  // Prefix decoder: a byte only advances the FSM on an enable strobe
  always_comb begin
    next_state = state;
    dec_fire   = 1'b0;
    dec_brk    = 1'b0;
    dec_key    = KEY_ENTER;
    if (received_data_en) begin
      case (state)
        IDLE: begin
          case (received_data)
            CODE_EXT:   next_state = EXT;
            CODE_BRK:   next_state = BRK;
            CODE_ENTER: dec_fire   = 1'b1;
            default:    next_state = IDLE;
          endcase
        end
        EXT: begin
          case (received_data)
            CODE_BRK: next_state = EXT_BRK;
            CODE_EXT: next_state = EXT;
            CODE_LEFT: begin
              dec_fire   = 1'b1;
              dec_key    = KEY_LEFT;
              next_state = IDLE;
            end
            CODE_RIGHT: begin
              dec_fire   = 1'b1;
              dec_key    = KEY_RIGHT;
              next_state = IDLE;
            end
            default: next_state = IDLE;
          endcase
        end
        BRK: begin
          next_state = IDLE;
          if (received_data == CODE_ENTER) begin
            dec_fire = 1'b1;
            dec_brk  = 1'b1;
          end
        end
        EXT_BRK: begin
          next_state = IDLE;
          if (received_data == CODE_LEFT) begin
            dec_fire = 1'b1;
            dec_brk  = 1'b1;
            dec_key  = KEY_LEFT;
          end else if (received_data == CODE_RIGHT) begin
            dec_fire = 1'b1;
            dec_brk  = 1'b1;
            dec_key  = KEY_RIGHT;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    key_mask = 3'b000;
    case (dec_key)
      KEY_ENTER: key_mask = 3'b100;
      KEY_LEFT:  key_mask = 3'b010;
      KEY_RIGHT: key_mask = 3'b001;
      default:   key_mask = 3'b000;
    endcase
  end

`ifdef KEY_TYPEMATIC_FILTER_EN
  assign evt_fire = dec_fire && (dec_brk || ((held_q & key_mask) == 3'b000));
`else
  assign evt_fire = dec_fire;
`endif

  assign full = (count == FULL_COUNT);
  assign pop  = evt_valid && evt_ready;
  assign push = evt_fire && (!full || pop);

  // Direction follows the last made key; releasing it falls back to the other key if still held
  always_comb begin
    held_next = held_q;
    move_next = move_q;
    if (evt_fire) begin
      if (dec_brk) begin
        held_next = held_q & ~key_mask;
        if (dec_key == KEY_LEFT && move_q == DIR_LEFT)
          move_next = held_next[0] ? DIR_RIGHT : DIR_NONE;
        else if (dec_key == KEY_RIGHT && move_q == DIR_RIGHT)
          move_next = held_next[1] ? DIR_LEFT : DIR_NONE;
      end else begin
        held_next = held_q | key_mask;
        if (dec_key == KEY_LEFT)
          move_next = DIR_LEFT;
        else if (dec_key == KEY_RIGHT)
          move_next = DIR_RIGHT;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      held_q     <= 3'b000;
      move_q     <= DIR_NONE;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state   <= next_state;
      held_q  <= held_next;
      move_q  <= move_next;
      start_q <= push && !dec_brk && (dec_key == KEY_ENTER);
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (evt_fire && full && !pop)
        overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: evt_code is masked while the queue is empty
  always_ff @(posedge CLOCK_50) begin
    if (push)
      mem[wr_ptr] <= {dec_brk, dec_key};
  end

  assign evt_valid   = (count != '0);
  assign evt_code    = evt_valid ? mem[rd_ptr] : 3'b000;
  assign held        = held_q;
  assign move_dir    = move_q;
  assign start_pulse = start_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Scoreboard bench for key_event_scheduler: directed scan-code vectors push expected events, a monitor pops and compares.
// Expectations for repeated ENTER makes follow KEY_TYPEMATIC_FILTER_EN.
module tb_key_event_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [2:0] held;
  logic [1:0] move_dir;
  logic       start_pulse;
  logic       overflow;

  int         n_vectors = 0;
  int         n_miscompares = 0;
  int         pulse_count = 0;
  int         pulse_base = 0;
  logic [2:0] exp_q [$];

  key_event_scheduler #(.FIFO_DEPTH(4)) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .evt_valid        (evt_valid),
    .evt_code         (evt_code),
    .evt_ready        (evt_ready),
    .held             (held),
    .move_dir         (move_dir),
    .start_pulse      (start_pulse),
    .overflow         (overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One byte strobe; the evt_ready level travels with the vector
  task automatic applyStimulus(input logic [7:0] code, input bit has_evt, input logic [2:0] exp_evt,
                               input logic rdy);
    @(posedge CLOCK_50);
    #1;
    received_data    = code;
    received_data_en = 1'b1;
    evt_ready        = rdy;
    if (has_evt)
      exp_q.push_back(exp_evt);
    @(posedge CLOCK_50);
    #1;
    received_data_en = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic monitorLoop();
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        if (start_pulse)
          pulse_count++;
        if (evt_valid && evt_ready) begin
          if (exp_q.size() == 0) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL unexpected_evt: got %0h, expected no event", evt_code);
          end else begin
            checkOutput("evt_code", {29'b0, evt_code}, {29'b0, exp_q.pop_front()});
          end
        end
      end
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_evt_valid"},   {31'b0, evt_valid},   32'd0);
    checkOutput({tag, "_evt_code"},    {29'b0, evt_code},    32'd0);
    checkOutput({tag, "_held"},        {29'b0, held},        32'd0);
    checkOutput({tag, "_move_dir"},    {30'b0, move_dir},    32'd0);
    checkOutput({tag, "_start_pulse"}, {31'b0, start_pulse}, 32'd0);
    checkOutput({tag, "_overflow"},    {31'b0, overflow},    32'd0);
  endtask

  initial begin
    fork
      monitorLoop();
    join_none

    // Asynchronous reset before the first clock edge
    #2 reset = 1'b1;
    #3;
    checkResetState("reset_async");
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50) reset = 1'b0;

    // Extended LEFT make then break, consumer always ready
    applyStimulus(8'hE0, 0, 3'b000, 1'b1);
    applyStimulus(8'h6B, 1, 3'b001, 1'b1);
    @(negedge CLOCK_50);
    checkOutput("left_make_valid", {31'b0, evt_valid}, 32'd1);
    checkOutput("left_make_held",  {29'b0, held},      32'b010);
    checkOutput("left_make_dir",   {30'b0, move_dir},  32'b01);
    applyStimulus(8'hE0, 0, 3'b000, 1'b1);
    applyStimulus(8'hF0, 0, 3'b000, 1'b1);
    applyStimulus(8'h6B, 1, 3'b101, 1'b1);
    @(negedge CLOCK_50);
    checkOutput("left_brk_held", {29'b0, held},     32'b000);
    checkOutput("left_brk_dir",  {30'b0, move_dir}, 32'b00);
    idleCycles(3);
    checkOutput("drained_valid", {31'b0, evt_valid}, 32'd0);

    // E0 5A and un-prefixed 6B are not events
    applyStimulus(8'hE0, 0, 3'b000, 1'b1);
    applyStimulus(8'h5A, 0, 3'b000, 1'b1);
    applyStimulus(8'h6B, 0, 3'b000, 1'b1);
    idleCycles(3);
    checkOutput("noevt_valid", {31'b0, evt_valid}, 32'd0);
    checkOutput("noevt_held",  {29'b0, held},      32'b000);

    // Direction priority: left, right, release right, release left
    applyStimulus(8'hE0, 0, 3'b000, 1'b1);
    applyStimulus(8'h6B, 1, 3'b001, 1'b1);
    @(negedge CLOCK_50);
    checkOutput("dir_left", {30'b0, move_dir}, 32'b01);
    applyStimulus(8'hE0, 0, 3'b000, 1'b1);
    applyStimulus(8'h74, 1, 3'b010, 1'b1);
    @(negedge CLOCK_50);
    checkOutput("dir_right",      {30'b0, move_dir}, 32'b10);
    checkOutput("dir_right_held", {29'b0, held},     32'b011);
    applyStimulus(8'hE0, 0, 3'b000, 1'b1);
    applyStimulus(8'hF0, 0, 3'b000, 1'b1);
    applyStimulus(8'h74, 1, 3'b110, 1'b1);
    @(negedge CLOCK_50);
    checkOutput("dir_fallback",      {30'b0, move_dir}, 32'b01);
    checkOutput("dir_fallback_held", {29'b0, held},     32'b010);
    applyStimulus(8'hE0, 0, 3'b000, 1'b1);
    applyStimulus(8'hF0, 0, 3'b000, 1'b1);
    applyStimulus(8'h6B, 1, 3'b101, 1'b1);
    @(negedge CLOCK_50);
    checkOutput("dir_none", {30'b0, move_dir}, 32'b00);
    idleCycles(3);

    // Typematic ENTER repeats with the consumer stalled
    pulse_base = pulse_count;
    applyStimulus(8'h5A, 1, 3'b000, 1'b0);
`ifdef KEY_TYPEMATIC_FILTER_EN
    applyStimulus(8'h5A, 0, 3'b000, 1'b0);
    applyStimulus(8'h5A, 0, 3'b000, 1'b0);
    idleCycles(2);
    checkOutput("typematic_pulses", pulse_count - pulse_base, 32'd1);
`else
    applyStimulus(8'h5A, 1, 3'b000, 1'b0);
    applyStimulus(8'h5A, 1, 3'b000, 1'b0);
    idleCycles(2);
    checkOutput("typematic_pulses", pulse_count - pulse_base, 32'd3);
`endif
    checkOutput("typematic_held",  {29'b0, held},      32'b100);
    checkOutput("typematic_valid", {31'b0, evt_valid}, 32'd1);
    evt_ready = 1'b1;
    idleCycles(6);
    checkOutput("typematic_drained", {31'b0, evt_valid}, 32'd0);
    applyStimulus(8'hF0, 0, 3'b000, 1'b1);
    applyStimulus(8'h5A, 1, 3'b100, 1'b1);
    idleCycles(3);
    checkOutput("enter_brk_held", {29'b0, held}, 32'b000);

    // Fill the depth-4 queue, then push and pop together while full
    applyStimulus(8'hE0, 0, 3'b000, 1'b0);
    applyStimulus(8'h6B, 1, 3'b001, 1'b0);
    applyStimulus(8'hE0, 0, 3'b000, 1'b0);
    applyStimulus(8'h74, 1, 3'b010, 1'b0);
    applyStimulus(8'hE0, 0, 3'b000, 1'b0);
    applyStimulus(8'hF0, 0, 3'b000, 1'b0);
    applyStimulus(8'h74, 1, 3'b110, 1'b0);
    applyStimulus(8'hE0, 0, 3'b000, 1'b0);
    applyStimulus(8'hF0, 0, 3'b000, 1'b0);
    applyStimulus(8'h6B, 1, 3'b101, 1'b0);
    @(negedge CLOCK_50);
    checkOutput("full_head",     {29'b0, evt_code},   32'b001);
    checkOutput("full_overflow", {31'b0, overflow},   32'd0);
    applyStimulus(8'hF0, 0, 3'b000, 1'b0);
    applyStimulus(8'h5A, 1, 3'b100, 1'b1);
    evt_ready = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("pushpop_overflow", {31'b0, overflow}, 32'd0);
    checkOutput("pushpop_head",     {29'b0, evt_code}, 32'b010);

    // Push on a full queue with no pop is dropped
    pulse_base = pulse_count;
    applyStimulus(8'h5A, 0, 3'b000, 1'b0);
    @(negedge CLOCK_50);
    checkOutput("drop_overflow", {31'b0, overflow}, 32'd1);
    checkOutput("drop_head",     {29'b0, evt_code}, 32'b010);
    idleCycles(2);
    checkOutput("drop_no_pulse", pulse_count - pulse_base, 32'd0);
    evt_ready = 1'b1;
    idleCycles(8);
    checkOutput("drop_drained",  {31'b0, evt_valid}, 32'd0);
    checkOutput("overflow_sticky", {31'b0, overflow}, 32'd1);

    // Reset after a lone E0 discards the prefix
    applyStimulus(8'hE0, 0, 3'b000, 1'b1);
    @(negedge CLOCK_50) reset = 1'b1;
    #2;
    checkResetState("reset_mid");
    exp_q.delete();
    @(negedge CLOCK_50) reset = 1'b0;
    applyStimulus(8'h6B, 0, 3'b000, 1'b1);
    idleCycles(3);
    checkOutput("post_reset_valid", {31'b0, evt_valid}, 32'd0);
    checkOutput("post_reset_held",  {29'b0, held},      32'b000);
    checkOutput("post_reset_dir",   {30'b0, move_dir},  32'b00);
    applyStimulus(8'hE0, 0, 3'b000, 1'b1);
    applyStimulus(8'h74, 1, 3'b010, 1'b1);
    idleCycles(3);
    checkOutput("post_reset_right", {30'b0, move_dir}, 32'b10);

    idleCycles(2);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
